// File: rtl/core_pkg.sv
// Shared core definitions: RV M-extension funct3/funct7 encodings, the
// multiply/divide FSM state type and the iteration-counter width helper.
package core_pkg;

  localparam int ISA__FUNCT3_WIDTH = 3;

  localparam logic [ISA__FUNCT3_WIDTH-1:0] ISA__FUNCT3_MUL    = 3'b000;
  localparam logic [ISA__FUNCT3_WIDTH-1:0] ISA__FUNCT3_MULH   = 3'b001;
  localparam logic [ISA__FUNCT3_WIDTH-1:0] ISA__FUNCT3_MULHSU = 3'b010;
  localparam logic [ISA__FUNCT3_WIDTH-1:0] ISA__FUNCT3_MULHU  = 3'b011;
  localparam logic [ISA__FUNCT3_WIDTH-1:0] ISA__FUNCT3_DIV    = 3'b100;
  localparam logic [ISA__FUNCT3_WIDTH-1:0] ISA__FUNCT3_DIVU   = 3'b101;
  localparam logic [ISA__FUNCT3_WIDTH-1:0] ISA__FUNCT3_REM    = 3'b110;
  localparam logic [ISA__FUNCT3_WIDTH-1:0] ISA__FUNCT3_REMU   = 3'b111;

  localparam logic [6:0] ISA__FUNCT7_MULDIV = 7'b0000001;

  typedef enum logic [1:0] {
    MD_IDLE,
    MD_CALC,
    MD_DONE
  } muldiv_state_e;

  // Counter must hold the value Width itself, hence the extra bit.
  function automatic int md_cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration, purely combinational.
//   acc/mcand      -> acc_nx          : shift-add multiply step (multiplier in acc low half)
//   rem/quo/divisor-> rem_nx, quo_nx  : restoring shift-subtract divide step
//                                       (dividend bits shift out of quo's MSB)
module muldiv_step #(
  parameter int Width = 32
) (
  input  logic [2*Width-1:0] acc,
  input  logic [Width-1:0]   mcand,
  input  logic [Width:0]     rem,
  input  logic [Width-1:0]   quo,
  input  logic [Width-1:0]   divisor,
  output logic [2*Width-1:0] acc_nx,
  output logic [Width:0]     rem_nx,
  output logic [Width-1:0]   quo_nx
);

  logic [Width:0]   psum;
  logic [Width+1:0] diff;

  always_comb begin
    psum   = {1'b0, acc[2*Width-1:Width]} + (acc[0] ? {1'b0, mcand} : '0);
    acc_nx = {psum, acc[Width-1:1]};

    // Shifted partial remainder needs Width+1 bits; one more bit carries the borrow.
    diff   = {rem, quo[Width-1]} - {2'b00, divisor};
    if (diff[Width+1]) begin
      rem_nx = {rem[Width-1:0], quo[Width-1]};
      quo_nx = {quo[Width-2:0], 1'b0};
    end else begin
      rem_nx = diff[Width:0];
      quo_nx = {quo[Width-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV M-extension multiply/divide unit (radix-2).
//   clk, rst_n           : clock, async active-low reset
//   in_valid/in_ready    : request handshake for a, b, op (funct3)
//   kill                 : synchronous abort of any in-flight operation
//   out_valid/out_ready  : result handshake for c
module muldiv_unit
  import core_pkg::*;
#(
  parameter int Width = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [Width-1:0]             a,
  input  logic [Width-1:0]             b,
  input  logic [ISA__FUNCT3_WIDTH-1:0] op,
  input  logic                         kill,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [Width-1:0]             c
);

  localparam int CntW = md_cnt_width(Width);
  localparam logic [Width-1:0] MinVal = {1'b1, {(Width-1){1'b0}}};

  muldiv_state_e                state;
  logic [CntW-1:0]              cnt;
  logic [ISA__FUNCT3_WIDTH-1:0] op_q;
  logic                         neg_q;   // product / quotient sign
  logic                         sa_q;    // dividend sign (remainder sign)
  logic                         fast_q;  // c already loaded at accept
  logic [2*Width-1:0]           acc;
  logic [Width-1:0]             opa_q, opb_q, quo;
  logic [Width:0]               rem;

  logic [2*Width-1:0]           acc_nx;
  logic [Width:0]               rem_nx;
  logic [Width-1:0]             quo_nx;

  logic                         a_signed, b_signed, sa, sb;
  logic [Width-1:0]             abs_a, abs_b;
  logic                         div_zero, div_ovf, fast;
  logic [Width-1:0]             fast_val;

  logic [2*Width-1:0]           prod;
  logic [Width-1:0]             quo_s, rem_s, result;

  muldiv_step #(.Width(Width)) u_step (
    .acc     (acc),
    .mcand   (opa_q),
    .rem     (rem),
    .quo     (quo),
    .divisor (opb_q),
    .acc_nx  (acc_nx),
    .rem_nx  (rem_nx),
    .quo_nx  (quo_nx)
  );

  // Request decode: operand signedness, magnitudes and the no-iteration cases.
  always_comb begin
    a_signed = 1'b0;
    b_signed = 1'b0;
    case (op)
      ISA__FUNCT3_MUL, ISA__FUNCT3_MULH,
      ISA__FUNCT3_DIV, ISA__FUNCT3_REM: begin
        a_signed = 1'b1;
        b_signed = 1'b1;
      end
      ISA__FUNCT3_MULHSU: a_signed = 1'b1;
      default: ;
    endcase
    sa       = a_signed & a[Width-1];
    sb       = b_signed & b[Width-1];
    abs_a    = sa ? -a : a;
    abs_b    = sb ? -b : b;
    div_zero = (b == '0);
    div_ovf  = (a == MinVal) && (b == '1);

    fast     = 1'b0;
    fast_val = '0;
    case (op)
      ISA__FUNCT3_DIV: begin
        fast     = div_zero | div_ovf;
        fast_val = div_zero ? '1 : MinVal;
      end
      ISA__FUNCT3_DIVU: begin
        fast     = div_zero;
        fast_val = '1;
      end
      ISA__FUNCT3_REM: begin
        fast     = div_zero | div_ovf;
        fast_val = div_zero ? a : '0;
      end
      ISA__FUNCT3_REMU: begin
        fast     = div_zero;
        fast_val = a;
      end
      ISA__FUNCT3_MUL, ISA__FUNCT3_MULH,
      ISA__FUNCT3_MULHSU, ISA__FUNCT3_MULHU: ;
      default: begin
        fast     = 1'b1;
        fast_val = '0;
      end
    endcase
  end

  // Final sign correction and result selection from the iterated registers.
  always_comb begin
    prod  = neg_q ? -acc : acc;
    quo_s = neg_q ? -quo : quo;
    rem_s = sa_q ? -rem[Width-1:0] : rem[Width-1:0];
    case (op_q)
      ISA__FUNCT3_MUL:                      result = prod[Width-1:0];
      ISA__FUNCT3_MULH, ISA__FUNCT3_MULHSU,
      ISA__FUNCT3_MULHU:                    result = prod[2*Width-1:Width];
      ISA__FUNCT3_DIV, ISA__FUNCT3_DIVU:    result = quo_s;
      ISA__FUNCT3_REM, ISA__FUNCT3_REMU:    result = rem_s;
      default:                              result = '0;
    endcase
  end

  // Both datapaths step every CALC cycle; op_q picks which one is meaningful.
  // DONE spends its first cycle registering c, so out_valid trails DONE entry by one edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= MD_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      c         <= '0;
      cnt       <= '0;
      op_q      <= '0;
      neg_q     <= 1'b0;
      sa_q      <= 1'b0;
      fast_q    <= 1'b0;
      acc       <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      quo       <= '0;
      rem       <= '0;
    end else if (kill) begin
      state     <= MD_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        MD_IDLE: begin
          if (in_valid && in_ready) begin
            op_q     <= op;
            neg_q    <= sa ^ sb;
            sa_q     <= sa;
            fast_q   <= fast;
            opa_q    <= abs_a;
            opb_q    <= abs_b;
            acc      <= {{Width{1'b0}}, abs_b};
            quo      <= abs_a;
            rem      <= '0;
            cnt      <= CntW'(Width);
            in_ready <= 1'b0;
            if (fast) begin
              c     <= fast_val;
              state <= MD_DONE;
            end else begin
              state <= MD_CALC;
            end
          end
        end
        MD_CALC: begin
          acc <= acc_nx;
          rem <= rem_nx;
          quo <= quo_nx;
          cnt <= cnt - 1'b1;
          if (cnt == CntW'(1)) state <= MD_DONE;
        end
        MD_DONE: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
            if (!fast_q) c <= result;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= MD_IDLE;
          end
        end
        default: state <= MD_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

  localparam int W = 32;
  localparam int TMO = 100;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic [2:0]    op = '0;
  logic          kill = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  c;

  int total = 0;
  int bad   = 0;

  muldiv_unit #(.Width(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .kill      (kill),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .c         (c)
  );

  always #5 clk = ~clk;

  // Reference model: RV M-extension semantics in 64-bit arithmetic.
  function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint     sx, sy, sp;
    logic [63:0] ux, uy, up;
    logic [31:0] r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'h0, x};
    uy = {32'h0, y};
    r  = '0;
    case (o)
      3'd0: begin sp = sx * sy; r = sp[31:0]; end
      3'd1: begin sp = sx * sy; r = sp[63:32]; end
      3'd2: begin sp = sx * longint'(uy); r = sp[63:32]; end
      3'd3: begin up = ux * uy; r = up[63:32]; end
      3'd4: begin
        if (y == 0) r = 32'hFFFF_FFFF;
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = 32'h8000_0000;
        else begin sp = sx / sy; r = sp[31:0]; end
      end
      3'd5: r = (y == 0) ? 32'hFFFF_FFFF : x / y;
      3'd6: begin
        if (y == 0) r = x;
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = 32'h0;
        else begin sp = sx % sy; r = sp[31:0]; end
      end
      default: r = (y == 0) ? x : x % y;
    endcase
    return r;
  endfunction

  function automatic int exp_lat(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    if (o[2] && y == 0) return 1;
    if ((o == 3'd4 || o == 3'd6) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
    return W + 1;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  // Drivers: inputs change and outputs are sampled 1 time unit after posedge.
  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    int n = 0;
    while (!in_ready && n < TMO) begin
      @(posedge clk); #1; n++;
    end
    op = o; a = x; b = y; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat, output bit ir_hi);
    lat = 0;
    ir_hi = 1'b0;
    do begin
      @(posedge clk); #1;
      lat++;
      if (in_ready) ir_hi = 1'b1;
    end while (!out_valid && lat < TMO);
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic do_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       output logic [31:0] res, output int lat, output bit ir_hi);
    issue(o, x, y);
    wait_valid(lat, ir_hi);
    res = c;
    consume();
  endtask

  task automatic test_reset();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    total++; if (c !== 32'h0) begin bad++; $display("FAIL reset_c: got %h want 0", c); end
  endtask

  typedef struct {
    logic [2:0]  o;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] e;
    int          l;
  } vec_t;

  task automatic test_directed();
    vec_t v[12];
    logic [31:0] res;
    int lat;
    bit ir_hi;
    v[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33};
    v[1]  = '{3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 33};
    v[2]  = '{3'd3, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 33};
    v[3]  = '{3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 33};
    v[4]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33};
    v[5]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33};
    v[6]  = '{3'd5, 32'd100,        32'd7,         32'd14,        33};
    v[7]  = '{3'd7, 32'd100,        32'd7,         32'd2,         33};
    v[8]  = '{3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF, 1};
    v[9]  = '{3'd6, 32'd5,          32'd0,         32'd5,         1};
    v[10] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1};
    v[11] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0,         1};
    for (int i = 0; i < 12; i++) begin
      do_op(v[i].o, v[i].x, v[i].y, res, lat, ir_hi);
      total++; if (res !== v[i].e) begin bad++; $display("FAIL directed_c[%0d]: got %h want %h", i, res, v[i].e); end
      total++; if (lat != v[i].l) begin bad++; $display("FAIL directed_latency[%0d]: got %0d want %0d", i, lat, v[i].l); end
      total++; if (ir_hi) begin bad++; $display("FAIL directed_in_ready_busy[%0d]: got 1 want 0", i); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL directed_in_ready_after[%0d]: got %b want 1", i, in_ready); end
    end
  endtask

  task automatic test_random();
    logic [2:0]  o;
    logic [31:0] x, y, res, e;
    int lat, el;
    bit ir_hi;
    for (int i = 0; i < 48; i++) begin
      o = 3'($urandom_range(0, 7));
      x = pick();
      y = pick();
      e = model(o, x, y);
      el = exp_lat(o, x, y);
      do_op(o, x, y, res, lat, ir_hi);
      total++; if (res !== e) begin bad++; $display("FAIL random_c op=%0d a=%h b=%h: got %h want %h", o, x, y, res, e); end
      total++; if (lat != el) begin bad++; $display("FAIL random_latency op=%0d: got %0d want %0d", o, lat, el); end
    end
  endtask

  task automatic test_handshake();
    logic [31:0] held, res;
    int lat;
    bit ir_hi;
    issue(3'd0, 32'd7, 32'hFFFF_FFFD);
    wait_valid(lat, ir_hi);
    held = c;
    total++; if (held !== 32'hFFFF_FFEB) begin bad++; $display("FAIL hs_first_c: got %h want ffffffeb", held); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      total++; if (out_valid !== 1'b1 || c !== held) begin bad++; $display("FAIL hs_hold[%0d]: got valid=%b c=%h want valid=1 c=%h", i, out_valid, c, held); end
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL hs_hold_in_ready[%0d]: got %b want 0", i, in_ready); end
    end
    out_ready = 1'b1;
    op = 3'd3; a = 32'hFFFF_FFFF; b = 32'h0000_0002; in_valid = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL hs_transfer: got valid=%b in_ready=%b want 0/1", out_valid, in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL hs_accept: got in_ready=%b want 0", in_ready); end
    wait_valid(lat, ir_hi);
    res = c;
    consume();
    total++; if (res !== 32'h1) begin bad++; $display("FAIL hs_second_c: got %h want 1", res); end
    total++; if (lat != W + 1) begin bad++; $display("FAIL hs_second_latency: got %0d want %0d", lat, W + 1); end
  endtask

  task automatic test_kill();
    logic [31:0] res;
    int lat;
    bit ir_hi, seen;
    issue(3'd4, 32'd1000, 32'd3);
    repeat (8) begin @(posedge clk); #1; end
    kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL kill_calc: got in_ready=%b valid=%b want 1/0", in_ready, out_valid); end
    seen = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (out_valid) seen = 1'b1; end
    total++; if (seen) begin bad++; $display("FAIL kill_no_result: got out_valid=1 want 0"); end
    do_op(3'd0, 32'd3, 32'd4, res, lat, ir_hi);
    total++; if (res !== 32'd12) begin bad++; $display("FAIL kill_next_c: got %h want c", res); end
    total++; if (lat != W + 1) begin bad++; $display("FAIL kill_next_latency: got %0d want %0d", lat, W + 1); end

    // kill beats accept in IDLE
    op = 3'd0; a = 32'd2; b = 32'd2; in_valid = 1'b1; kill = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; kill = 1'b0;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL kill_idle_accept: got in_ready=%b want 1", in_ready); end
    repeat (3) begin @(posedge clk); #1; end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL kill_idle_valid: got %b want 0", out_valid); end

    // kill beats out_ready in DONE
    issue(3'd5, 32'd5, 32'd0);
    wait_valid(lat, ir_hi);
    kill = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0; out_ready = 1'b0;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL kill_done: got valid=%b in_ready=%b want 0/1", out_valid, in_ready); end
  endtask

  task automatic test_async_reset();
    logic [31:0] res;
    int lat;
    bit ir_hi;
    do_op(3'd0, 32'd3, 32'd5, res, lat, ir_hi);
    issue(3'd0, 32'h1234_5678, 32'h9ABC_DEF1);
    repeat (5) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL areset_in_ready: got %b want 1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL areset_out_valid: got %b want 0", out_valid); end
    total++; if (c !== 32'h0) begin bad++; $display("FAIL areset_c: got %h want 0", c); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    do_op(3'd5, 32'd100, 32'd7, res, lat, ir_hi);
    total++; if (res !== 32'd14) begin bad++; $display("FAIL areset_next_c: got %h want e", res); end
  endtask

  initial begin
    #12;
    test_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_directed();
    test_random();
    test_handshake();
    test_kill();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit implementing the RV M-extension (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU), parametrised in operand width.
- Sits beside the single-cycle ALU in the execute stage. It is selected when funct7 marks an M-extension op, and it stalls the pipeline through a valid/ready handshake.
- Radix-2: one product or quotient bit per cycle. Divide-by-zero and signed overflow take a fast path.

Parameters:
- Width, 32, operand/result width in bits; must be ≥ 2.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  request present on a, b, op.
- in_ready  output  1  unit idle and able to accept a request.
- a  input  Width  rs1 operand.
- b  input  Width  rs2 operand.
- op  input  ISA__FUNCT3_WIDTH  M-extension funct3 selector.
- kill  input  1  synchronous abort of the in-flight operation (pipeline flush).
- out_valid  output  1  result c is valid.
- out_ready  input  1  consumer takes the result.
- c  output  Width  result.

Behaviour:
- Reset (rst_n low, async): state IDLE, in_ready=1, out_valid=0, c=0, counter=0, all datapath registers 0.
- States: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - Accept on in_valid&&in_ready: latch op, operand signs and |a|, |b|.
  - Signed ops use absolute values; for MULHSU only a is treated as signed.
  - Go to CALC with counter=Width. For fast-path cases, go directly to DONE.
- CALC:
  - One iteration per cycle; counter decrements; at counter==1 go to DONE.
  - Multiply: shift-add into a 2*Width accumulator.
  - Divide: restoring shift-subtract, with Width+1-bit remainder.
- DONE:
  - out_valid=1; c is held stable until the transfer.
  - On out_valid&&out_ready, go to IDLE. in_ready rises the following cycle, so there is no same-cycle accept.
- Latency: out_valid rises exactly Width+1 cycles after the accepting edge (33 for Width=32). Fast path: 1 cycle.
- Result selection:
  - MUL: low Width bits of the product.
  - MULH/MULHSU/MULHU: high Width bits. The 2*Width product is negated first when the operand signs differ (signed cases only).
  - DIV/DIVU: quotient. For DIV, negated when the signs differ.
  - REM/REMU: remainder. For REM, takes the sign of the dividend.
- Fast path, no iteration:
  - b==0: DIV/DIVU give all ones; REM/REMU give a.
  - DIV with a==MIN (1 followed by Width-1 zeros) and b==all ones: quotient = MIN.
  - REM with the same operands: 0.
- kill:
  - In any state, next state is IDLE and out_valid=0; the result is discarded.
  - kill has priority over accept and over out_ready in the same cycle. kill in IDLE with in_valid means no accept.
- Reset mid-operation: immediate return to the reset values; no partial result is visible.
- Unknown op: unreachable by decode. If accepted, it completes via the fast path with c=0.

Decomposition:
- Add M-extension funct3 constants to the shared ISA header: ISA__FUNCT3_MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU, plus ISA__FUNCT7_MULDIV.
- State enum and iteration-count width ($clog2(Width)+1) go in a core package (core_pkg) for reuse by the hazard unit.
- One natural sub-module, muldiv_step: combinational single iteration (add-or-not / subtract-or-restore) on accumulator, remainder and partial quotient. This keeps the FSM and sign handling in muldiv_unit.

Test Plan (Width=32):
- MUL a=7, b=-3 (0xFFFFFFFD) → c=0xFFFFFFEB.
  - Check: out_valid exactly 33 cycles after accept; in_ready low throughout.
- MULH a=0x80000000, b=0x80000000 → 0x40000000.
  - MULHU with the same operands → 0x40000000.
  - MULHSU a=0xFFFFFFFF, b=0xFFFFFFFF → 0xFFFFFFFF.
- DIV a=-7, b=2 → 0xFFFFFFFD.
  - REM with the same operands → 0xFFFFFFFF.
  - DIVU a=100, b=7 → 14; REMU with the same operands → 2.
- Fast path:
  - DIVU a=5, b=0 → 0xFFFFFFFF in 1 cycle; REM a=5, b=0 → 5.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM with the same operands → 0.
- Handshake:
  - Hold out_ready=0 for 5 cycles after done: c and out_valid are stable.
  - Then assert out_ready: in_ready=1 on the next cycle.
  - in_valid held high: the next op is accepted on that cycle, not earlier.
- kill/reset:
  - kill at cycle 10 of a DIV → IDLE next cycle, no out_valid; a following MUL 3*4=12 is correct.
  - rst_n pulsed low mid-CALC → outputs at reset values asynchronously.
